// File: rtl/exe_conv_arbiter_if.sv
// Handshake bundle between the operand-issue ports, the shared
// sign-magnitude conversion unit and the response consumer.
interface exe_conv_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ*WIDTH-1:0] i_req_arg;
    logic [NREQ-1:0]       o_req_ready;
    logic [WIDTH-1:0]      o_conv_arg;
    logic [WIDTH-1:0]      i_conv_result;
    logic                  i_conv_error;
    logic                  o_rsp_valid;
    logic [IDW-1:0]        o_rsp_id;
    logic [WIDTH-1:0]      o_rsp_result;
    logic                  o_rsp_error;
    logic                  i_rsp_ready;
    logic                  o_busy;

    modport slave (
        input  i_req_valid, i_req_arg, i_conv_result,
        input  i_conv_error, i_rsp_ready,
        output o_req_ready, o_conv_arg, o_rsp_valid,
        output o_rsp_id, o_rsp_result, o_rsp_error, o_busy
    );

    modport master (
        output i_req_valid, i_req_arg, i_conv_result,
        output i_conv_error, i_rsp_ready,
        input  o_req_ready, o_conv_arg, o_rsp_valid,
        input  o_rsp_id, o_rsp_result, o_rsp_error, o_busy
    );
endinterface

// File: rtl/exe_conv_arbiter.sv
// Round-robin arbiter sharing one combinational sign-magnitude to
// two's-complement unit between NREQ requesters; one op per 2 cycles.
module exe_conv_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input logic              i_clk,
    input logic              i_rst,
    exe_conv_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [IDW-1:0]   win;
    logic             found;
    logic             grant_en;
    logic             grant;

    // Search from the pointer upward, wrapping, for the first valid requester.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = ptr_q;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && bus.i_req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    // Reset gating keeps the grant vector quiet while i_rst is held.
    assign grant_en = !i_rst &&
                      ((state_q == IDLE) ||
                       ((state_q == RESP) && bus.i_rsp_ready));
    assign grant    = grant_en && found;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        arg_d   = arg_q;
        res_d   = res_q;
        err_d   = err_q;
        if (grant) begin
            arg_d = bus.i_req_arg[win*WIDTH +: WIDTH];
            id_d  = win;
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (grant) state_d = EXEC;
            end
            EXEC: begin
                res_d   = bus.i_conv_result;
                err_d   = bus.i_conv_error;
                state_d = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) state_d = grant ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            arg_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            arg_q   <= arg_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_req_ready  = grant ? (NREQ'(1) << win) : '0;
    assign bus.o_conv_arg   = (state_q == EXEC) ? arg_q : '0;
    assign bus.o_rsp_valid  = (state_q == RESP);
    assign bus.o_rsp_id     = id_q;
    assign bus.o_rsp_result = res_q;
    assign bus.o_rsp_error  = err_q;
    assign bus.o_busy       = (state_q != IDLE);
endmodule
